// File: rtl/cargador_programa_pkg.sv
// cargador_pkg: shared definitions for the program loader.
//   - estado_t: loader FSM state encoding, also visible to the host through
//     the loader interface for observation.
//   - ANCHO_DIR_DEF / ANCHO_DATO_DEF: default memory address and word widths.
//   - OP_*: processor opcodes, the upper nibble of a program word
//     ({opcode[3:0], operand[7:0]}).
//   - escribe_memoria(): true in the states where the processor memory is
//     in write mode (wr=1).
package cargador_pkg;

    localparam int ANCHO_DIR_DEF  = 6;
    localparam int ANCHO_DATO_DEF = 12;

    typedef enum logic [2:0] {
        RST_CPU = 3'd0,
        CLEAR   = 3'd1,
        LOAD    = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } estado_t;

    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_XOR   = 4'd9;
    localparam logic [3:0] OP_NOT   = 4'd10;
    localparam logic [3:0] OP_JMP   = 4'd11;
    localparam logic [3:0] OP_INC   = 4'd12;
    localparam logic [3:0] OP_DEC   = 4'd13;
    localparam logic [3:0] OP_SHL   = 4'd14;
    localparam logic [3:0] OP_SHR   = 4'd15;

    // The processor memory stays in write mode from reset until the program
    // has been fully loaded.
    function automatic logic escribe_memoria(estado_t e);
        return (e == RST_CPU) || (e == CLEAR) || (e == LOAD);
    endfunction

endpackage

// File: rtl/cargador_programa_if.sv
// cargador_programa_if: host-to-loader program word channel.
//   in_valid  host -> loader  host offers a word
//   in_ready  loader -> host  loader accepts the offered word this cycle
//   in_dir    host -> loader  target address of the word
//   in_dato   host -> loader  word to write
//   in_fin    host -> loader  the word is the last word of the program
//   estado    loader -> host  current loader FSM state (observation only)
//
// Handshake: a word transfers on a rising clock edge where in_valid and
// in_ready are both high. in_ready is registered and does not depend on
// in_valid. While in_ready is low an offered word is ignored, never queued,
// so the host keeps it on the bus until it is accepted. After a transfer the
// host either presents the next word or drops in_valid.
interface cargador_programa_if
    import cargador_pkg::*;
#(
    parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
    parameter int ANCHO_DATO = ANCHO_DATO_DEF
);

    logic                  in_valid;
    logic                  in_ready;
    logic [ANCHO_DIR-1:0]  in_dir;
    logic [ANCHO_DATO-1:0] in_dato;
    logic                  in_fin;
    estado_t               estado;

    modport master (
        output in_valid,
        output in_dir,
        output in_dato,
        output in_fin,
        input  in_ready,
        input  estado
    );

    modport slave (
        input  in_valid,
        input  in_dir,
        input  in_dato,
        input  in_fin,
        output in_ready,
        output estado
    );

endinterface

// File: rtl/cargador_programa_monitor_acumulador.sv
// monitor_acumulador: tracks the processor accumulator while the program runs.
//   clk, reset         clock, synchronous active-high reset
//   estado             loader FSM state; tracking is enabled only in RUN
//   dato_saliente      processor accumulator
//   acumulador_ultimo  last accumulator value that differed from the previous
//                      cycle while in RUN
//   cambios            number of such changes, saturating at 255
// The sample register follows the accumulator in every state, so the first
// RUN cycle compares against the value present just before RUN began.
module monitor_acumulador
    import cargador_pkg::*;
#(
    parameter int ANCHO_DATO = ANCHO_DATO_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  estado_t               estado,
    input  logic [ANCHO_DATO-1:0] dato_saliente,
    output logic [ANCHO_DATO-1:0] acumulador_ultimo,
    output logic [7:0]            cambios
);

    logic [ANCHO_DATO-1:0] muestra_q, muestra_d;
    logic [ANCHO_DATO-1:0] acum_q, acum_d;
    logic [7:0]            cambios_q, cambios_d;

    always_comb begin
        muestra_d = dato_saliente;
        acum_d    = acum_q;
        cambios_d = cambios_q;
        if ((estado == RUN) && (dato_saliente != muestra_q)) begin
            acum_d = dato_saliente;
            if (cambios_q != 8'hFF) begin
                cambios_d = cambios_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            muestra_q <= '0;
            acum_q    <= '0;
            cambios_q <= '0;
        end else begin
            muestra_q <= muestra_d;
            acum_q    <= acum_d;
            cambios_q <= cambios_d;
        end
    end

    assign acumulador_ultimo = acum_q;
    assign cambios           = cambios_q;

endmodule

// File: rtl/cargador_programa.sv
// cargador_programa: loads a program into a small processor's memory, runs
// it for a fixed budget of cycles and reports the accumulator activity.
//   clk, reset         clock, synchronous active-high reset
//   host               program word channel (slave side), exposes FSM state
//   reset_cpu          processor reset
//   wr                 processor memory write mode (1) / execute (0)
//   direccion          processor memory address
//   datoEntrante       processor memory write data
//   datoSaliente       processor accumulator
//   ejecutando         processor is running
//   hecho              execution budget expired
//   acumulador_ultimo  last accumulator value captured during RUN
//   cambios            accumulator changes during RUN, saturating at 255
// Sequence: RST_CPU holds the processor in reset, CLEAR zeroes every memory
// word, LOAD writes the host's words, RUN lets the processor execute, DONE
// holds until reset. Every output comes straight from a flop; the output
// flops are loaded from the next-state values so they line up with the state
// register.
module cargador_programa
    import cargador_pkg::*;
#(
    parameter int ANCHO_DIR        = ANCHO_DIR_DEF,
    parameter int ANCHO_DATO       = ANCHO_DATO_DEF,
    parameter int CICLOS_RESET     = 6,
    parameter int CICLOS_ESCRITURA = 2,
    parameter int CICLOS_EJEC      = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    cargador_programa_if.slave    host,
    output logic                  reset_cpu,
    output logic                  wr,
    output logic [ANCHO_DIR-1:0]  direccion,
    output logic [ANCHO_DATO-1:0] datoEntrante,
    input  logic [ANCHO_DATO-1:0] datoSaliente,
    output logic                  ejecutando,
    output logic                  hecho,
    output logic [ANCHO_DATO-1:0] acumulador_ultimo,
    output logic [7:0]            cambios
);

    // One counter serves every timed phase: reset hold, per-word write hold
    // and the execution budget.
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] FIN_RESET     = CNT_W'(CICLOS_RESET - 1);
    localparam logic [CNT_W-1:0] FIN_ESCRITURA = CNT_W'(CICLOS_ESCRITURA - 1);
    localparam logic [CNT_W-1:0] FIN_EJEC      = CNT_W'(CICLOS_EJEC - 1);

    estado_t               state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hold_q, hold_d;       // a LOAD write is being held
    logic                  fin_q, fin_d;         // held word is the last one
    logic [ANCHO_DIR-1:0]  dir_q, dir_d;
    logic [ANCHO_DATO-1:0] dato_q, dato_d;
    logic                  reset_cpu_q, reset_cpu_d;
    logic                  wr_q, wr_d;
    logic                  in_ready_q, in_ready_d;
    logic                  ejecutando_q, ejecutando_d;
    logic                  hecho_q, hecho_d;

    // Next state and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        fin_d   = fin_q;
        dir_d   = dir_q;
        dato_d  = dato_q;

        case (state_q)
            RST_CPU: begin
                if (cnt_q == FIN_RESET) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    dir_d   = '0;
                    dato_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Walk every address once, writing zero, each held for the
            // write time. The last address is left on the bus into LOAD.
            CLEAR: begin
                dato_d = '0;
                if (cnt_q == FIN_ESCRITURA) begin
                    cnt_d = '0;
                    if (dir_q == '1) begin
                        state_d = LOAD;
                        hold_d  = 1'b0;
                    end else begin
                        dir_d = dir_q + ANCHO_DIR'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            LOAD: begin
                if (hold_q) begin
                    if (cnt_q == FIN_ESCRITURA) begin
                        hold_d = 1'b0;
                        cnt_d  = '0;
                        if (fin_q) begin
                            state_d = RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (host.in_valid && in_ready_q) begin
                    // in_ready_q is only high here, so this is the transfer.
                    hold_d = 1'b1;
                    cnt_d  = '0;
                    dir_d  = host.in_dir;
                    dato_d = host.in_dato;
                    fin_d  = host.in_fin;
                end
            end

            RUN: begin
                if (cnt_q == FIN_EJEC) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = RST_CPU;
                cnt_d   = '0;
            end
        endcase
    end

    // Output flops are loaded from the next state so they match state_q.
    always_comb begin
        reset_cpu_d  = (state_d == RST_CPU);
        wr_d         = escribe_memoria(state_d);
        in_ready_d   = (state_d == LOAD) && !hold_d;
        ejecutando_d = (state_d == RUN);
        hecho_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RST_CPU;
            cnt_q        <= '0;
            hold_q       <= 1'b0;
            fin_q        <= 1'b0;
            dir_q        <= '0;
            dato_q       <= '0;
            reset_cpu_q  <= 1'b1;
            wr_q         <= 1'b1;
            in_ready_q   <= 1'b0;
            ejecutando_q <= 1'b0;
            hecho_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            fin_q        <= fin_d;
            dir_q        <= dir_d;
            dato_q       <= dato_d;
            reset_cpu_q  <= reset_cpu_d;
            wr_q         <= wr_d;
            in_ready_q   <= in_ready_d;
            ejecutando_q <= ejecutando_d;
            hecho_q      <= hecho_d;
        end
    end

    monitor_acumulador #(
        .ANCHO_DATO (ANCHO_DATO)
    ) u_monitor (
        .clk               (clk),
        .reset             (reset),
        .estado            (state_q),
        .dato_saliente     (datoSaliente),
        .acumulador_ultimo (acumulador_ultimo),
        .cambios           (cambios)
    );

    assign host.in_ready = in_ready_q;
    assign host.estado   = state_q;
    assign reset_cpu     = reset_cpu_q;
    assign wr            = wr_q;
    assign direccion     = dir_q;
    assign datoEntrante  = dato_q;
    assign ejecutando    = ejecutando_q;
    assign hecho         = hecho_q;

endmodule

// File: tb/tb_cargador_programa.sv
// Bench for cargador_programa: a main instance with a 10-cycle execution
// budget and a second instance with a 300-cycle budget to reach the
// saturation of the change counter. Inputs are driven and outputs checked on
// the falling clock edge.
module tb_cargador_programa;
    import cargador_pkg::*;

    localparam int AD     = 6;
    localparam int AW     = 12;
    localparam int EJEC   = 10;
    localparam int EJEC_S = 300;

    typedef struct packed {
        logic [AD-1:0] dir;
        logic [AW-1:0] dato;
        logic          fin;
    } word_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    cargador_programa_if #(.ANCHO_DIR(AD), .ANCHO_DATO(AW)) bus ();
    cargador_programa_if #(.ANCHO_DIR(AD), .ANCHO_DATO(AW)) bus_s ();

    logic          reset_cpu, wr, ejecutando, hecho;
    logic [AD-1:0] direccion;
    logic [AW-1:0] dato_ent, dato_sal, acum;
    logic [7:0]    cambios;

    logic          reset_cpu_s, wr_s, ejecutando_s, hecho_s;
    logic [AD-1:0] direccion_s;
    logic [AW-1:0] dato_ent_s, dato_sal_s, acum_s;
    logic [7:0]    cambios_s;

    cargador_programa #(
        .ANCHO_DIR(AD), .ANCHO_DATO(AW), .CICLOS_RESET(6),
        .CICLOS_ESCRITURA(2), .CICLOS_EJEC(EJEC)
    ) dut (
        .clk(clk), .reset(reset), .host(bus),
        .reset_cpu(reset_cpu), .wr(wr), .direccion(direccion),
        .datoEntrante(dato_ent), .datoSaliente(dato_sal),
        .ejecutando(ejecutando), .hecho(hecho),
        .acumulador_ultimo(acum), .cambios(cambios)
    );

    cargador_programa #(
        .ANCHO_DIR(AD), .ANCHO_DATO(AW), .CICLOS_RESET(6),
        .CICLOS_ESCRITURA(2), .CICLOS_EJEC(EJEC_S)
    ) dut_s (
        .clk(clk), .reset(reset), .host(bus_s),
        .reset_cpu(reset_cpu_s), .wr(wr_s), .direccion(direccion_s),
        .datoEntrante(dato_ent_s), .datoSaliente(dato_sal_s),
        .ejecutando(ejecutando_s), .hecho(hecho_s),
        .acumulador_ultimo(acum_s), .cambios(cambios_s)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    word_t         prog_q[$];
    logic [AW-1:0] run_vals[$];
    logic [AW-1:0] mem_exp[64];   // memory contents the processor should see
    logic [AW-1:0] mem_obs[64];   // memory contents built from the write bus

    // Processor memory as seen from its bus: written whenever it is out of
    // reset and in write mode.
    always @(negedge clk) begin
        if (wr === 1'b1 && reset_cpu === 1'b0) begin
            mem_obs[direccion] = dato_ent;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic word_t mk(input logic [AD-1:0] d, input logic [AW-1:0] v, input logic f);
        word_t w;
        w.dir  = d;
        w.dato = v;
        w.fin  = f;
        return w;
    endfunction

    task automatic gen_program(input int n);
        word_t w;
        prog_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0)
                w.dir = prog_q[$urandom_range(0, i - 1)].dir;   // duplicate address
            else
                w.dir = AD'($urandom_range(0, 63));
            w.dato = {4'($urandom_range(1, 15)), 8'($urandom_range(0, 255))};
            w.fin  = (i == n - 1);
            prog_q.push_back(w);
        end
    endtask

    // Assert reset for one edge; returns on the falling edge after it with
    // reset still high. Scrambles the observed memory so CLEAR must rewrite it.
    task automatic apply_reset();
        bus.in_valid   = 1'b0;
        bus_s.in_valid = 1'b0;
        dato_sal       = '0;
        dato_sal_s     = '0;
        for (int a = 0; a < 64; a++) mem_obs[a] = AW'($urandom);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string ctx);
        n_tests++;
        if ({reset_cpu, wr, bus.in_ready, ejecutando, hecho} !== 5'b11000) begin
            n_fail++;
            $display("FAIL %s ctrl {reset_cpu,wr,in_ready,ejec,hecho}: got %b want 11000",
                     ctx, {reset_cpu, wr, bus.in_ready, ejecutando, hecho});
        end
        n_tests++;
        if (direccion !== '0 || dato_ent !== '0) begin
            n_fail++;
            $display("FAIL %s bus: got dir=%0d dato=%h want 0/000", ctx, direccion, dato_ent);
        end
        n_tests++;
        if (cambios !== 8'd0 || acum !== '0) begin
            n_fail++;
            $display("FAIL %s tracking: got cambios=%0d acum=%h want 0/000", ctx, cambios, acum);
        end
        n_tests++;
        if (bus.estado !== RST_CPU) begin
            n_fail++;
            $display("FAIL %s estado: got %0d want RST_CPU", ctx, bus.estado);
        end
    endtask

    // Called on the falling edge right after the last reset edge with reset
    // already released. Offers garbage words throughout, which must be
    // ignored. Returns on the first LOAD falling edge.
    task automatic check_startup(input string ctx);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_dir   = AD'($urandom);
            bus.in_dato  = AW'($urandom);
            bus.in_fin   = 1'($urandom);
            n_tests++;
            if ({reset_cpu, wr, bus.in_ready} !== 3'b110) begin
                n_fail++;
                $display("FAIL %s rst_cpu cycle %0d: got {reset_cpu,wr,in_ready}=%b want 110",
                         ctx, i, {reset_cpu, wr, bus.in_ready});
            end
            @(negedge clk);
        end
        for (int a = 0; a < 64; a++) begin
            for (int h = 0; h < 2; h++) begin
                bus.in_valid = 1'b1;
                bus.in_dir   = AD'($urandom);
                bus.in_dato  = AW'($urandom);
                bus.in_fin   = 1'($urandom);
                n_tests++;
                if ({reset_cpu, wr, bus.in_ready} !== 3'b010 || direccion !== AD'(a) || dato_ent !== '0) begin
                    n_fail++;
                    $display("FAIL %s clear addr %0d hold %0d: got ctrl=%b dir=%0d dato=%h want 010/%0d/000",
                             ctx, a, h, {reset_cpu, wr, bus.in_ready}, direccion, dato_ent, a);
                end
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if ({reset_cpu, wr, bus.in_ready, ejecutando} !== 4'b0110) begin
            n_fail++;
            $display("FAIL %s load_entry: got {reset_cpu,wr,in_ready,ejec}=%b want 0110",
                     ctx, {reset_cpu, wr, bus.in_ready, ejecutando});
        end
        for (int a = 0; a < 64; a++) mem_exp[a] = '0;
    endtask

    // Sends prog_q. gaps=0 keeps in_valid high with the next word during each
    // hold; gaps=1 drops it and idles randomly. abort_at>=0 asserts reset in
    // the first hold cycle of that word and returns on the falling edge after
    // the reset edge.
    task automatic send_program(input string ctx, input int abort_at, input bit gaps);
        int    t;
        word_t w;
        for (int i = 0; i < prog_q.size(); i++) begin
            w = prog_q[i];
            if (!bus.in_valid) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_dir   = w.dir;
            bus.in_dato  = w.dato;
            bus.in_fin   = w.fin;
            t = 0;
            while (bus.in_ready !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            n_tests++;
            if (t >= 20) begin
                n_fail++;
                $display("FAIL %s accept word %0d: in_ready still %b after 20 cycles, want 1", ctx, i, bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);   // transfer edge has passed: first hold cycle
            mem_exp[w.dir] = w.dato;
            if (i + 1 < prog_q.size() && !gaps) begin
                bus.in_valid = 1'b1;
                bus.in_dir   = prog_q[i + 1].dir;
                bus.in_dato  = prog_q[i + 1].dato;
                bus.in_fin   = prog_q[i + 1].fin;
            end else begin
                bus.in_valid = 1'b0;
            end
            for (int h = 0; h < 2; h++) begin
                n_tests++;
                if ({reset_cpu, wr, bus.in_ready, ejecutando} !== 4'b0100 ||
                    direccion !== w.dir || dato_ent !== w.dato) begin
                    n_fail++;
                    $display("FAIL %s hold word %0d cycle %0d: got ctrl=%b dir=%0d dato=%h want 0100/%0d/%h",
                             ctx, i, h, {reset_cpu, wr, bus.in_ready, ejecutando}, direccion, dato_ent, w.dir, w.dato);
                end
                if (i == abort_at) begin
                    bus.in_valid = 1'b0;
                    reset = 1'b1;
                    @(negedge clk);
                    return;
                end
                @(negedge clk);
            end
            n_tests++;
            if (w.fin) begin
                if ({wr, bus.in_ready, ejecutando, hecho} !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL %s run_entry: got {wr,in_ready,ejec,hecho}=%b want 0010",
                             ctx, {wr, bus.in_ready, ejecutando, hecho});
                end
            end else begin
                if ({wr, bus.in_ready, ejecutando} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL %s ready_after_word %0d: got {wr,in_ready,ejec}=%b want 110",
                             ctx, i, {wr, bus.in_ready, ejecutando});
                end
            end
        end
    endtask

    task automatic check_memory(input string ctx);
        for (int a = 0; a < 64; a++) begin
            n_tests++;
            if (mem_obs[a] !== mem_exp[a]) begin
                n_fail++;
                $display("FAIL %s mem[%0d]: got %h want %h", ctx, a, mem_obs[a], mem_exp[a]);
            end
        end
    endtask

    // Called on the first RUN falling edge. Drives run_vals one per cycle;
    // only the first EJEC of them fall inside RUN.
    task automatic run_and_check(input string ctx);
        logic [AW-1:0] prev, last_exp;
        int            cnt_exp;
        prev     = dato_sal;
        last_exp = '0;
        cnt_exp  = 0;
        for (int k = 1; k <= run_vals.size(); k++) begin
            dato_sal = run_vals[k - 1];
            @(negedge clk);
            if (k <= EJEC && run_vals[k - 1] != prev) begin
                cnt_exp  = (cnt_exp < 255) ? cnt_exp + 1 : 255;
                last_exp = run_vals[k - 1];
            end
            prev = run_vals[k - 1];
            n_tests++;
            if (cambios !== 8'(cnt_exp) || acum !== last_exp) begin
                n_fail++;
                $display("FAIL %s track k=%0d: got cambios=%0d acum=%h want %0d/%h",
                         ctx, k, cambios, acum, cnt_exp, last_exp);
            end
            n_tests++;
            if ({wr, ejecutando, hecho} !== {1'b0, (k < EJEC), (k >= EJEC)}) begin
                n_fail++;
                $display("FAIL %s phase k=%0d: got {wr,ejec,hecho}=%b want %b",
                         ctx, k, {wr, ejecutando, hecho}, {1'b0, (k < EJEC), (k >= EJEC)});
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        check_reset_state("reset");
        reset = 1'b0;
        check_startup("startup");
    endtask

    task automatic test_load_fixed();
        prog_q.delete();
        prog_q.push_back(mk(6'd20, 12'd5,    1'b0));
        prog_q.push_back(mk(6'd21, 12'd15,   1'b0));
        prog_q.push_back(mk(6'd0,  12'h114,  1'b0));
        prog_q.push_back(mk(6'd1,  12'h315,  1'b0));
        prog_q.push_back(mk(6'd2,  12'h216,  1'b1));
        send_program("fixed", -1, 1'b0);
        check_memory("fixed");
    endtask

    task automatic test_run_tracking();
        run_vals.delete();
        run_vals.push_back(12'd5);
        run_vals.push_back(12'd20);
        run_vals.push_back(12'd20);
        run_vals.push_back(12'd0);
        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 2))
                0:       run_vals.push_back(run_vals[run_vals.size() - 1]);
                1:       run_vals.push_back(12'd0);
                default: run_vals.push_back(AW'($urandom_range(1, 4095)));
            endcase
        end
        for (int i = 0; i < 4; i++) run_vals.push_back(AW'($urandom_range(1, 4095)));
        run_and_check("run_fixed");
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        check_reset_state("reset_from_done");
        reset = 1'b0;
        check_startup("startup2");
        gen_program(6);
        send_program("abort", 3, 1'b0);
        check_reset_state("abort_write");
        reset = 1'b0;
        check_startup("startup_after_abort");
        gen_program($urandom_range(5, 12));
        send_program("random_gaps", -1, 1'b1);
        check_memory("random_gaps");
        run_vals.delete();
        for (int i = 0; i < EJEC + 3; i++) begin
            if ($urandom_range(0, 2) == 0 && run_vals.size() > 0)
                run_vals.push_back(run_vals[run_vals.size() - 1]);
            else
                run_vals.push_back(AW'($urandom_range(0, 4095)));
        end
        run_and_check("run_random");
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        reset = 1'b0;
        check_startup("startup3");
        gen_program(3);
        send_program("pre_run", -1, 1'($urandom));
        check_memory("pre_run");
        for (int k = 1; k <= 4; k++) begin
            dato_sal = AW'(k * 200 + $urandom_range(0, 50));
            @(negedge clk);
        end
        n_tests++;
        if (cambios !== 8'd4 || ejecutando !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_progress: got cambios=%0d ejec=%b want 4/1", cambios, ejecutando);
        end
        reset = 1'b1;
        @(negedge clk);
        dato_sal = '0;
        check_reset_state("abort_run");
        reset = 1'b0;
        check_startup("startup_after_run_abort");
    endtask

    task automatic test_saturation();
        int            t, cnt_exp;
        logic [AW-1:0] v, prev, last_exp;
        apply_reset();
        n_tests++;
        if ({reset_cpu_s, wr_s, ejecutando_s, hecho_s} !== 4'b1100 || cambios_s !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_reset: got ctrl=%b cambios=%0d want 1100/0",
                     {reset_cpu_s, wr_s, ejecutando_s, hecho_s}, cambios_s);
        end
        reset = 1'b0;
        bus_s.in_valid = 1'b1;
        bus_s.in_dir   = 6'd7;
        bus_s.in_dato  = {OP_INC, 8'h01};
        bus_s.in_fin   = 1'b1;
        t = 0;
        while (ejecutando_s !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (t >= 400) begin
            n_fail++;
            $display("FAIL sat_run_entry: ejecutando still %b after 400 cycles, want 1", ejecutando_s);
            bus_s.in_valid = 1'b0;
            return;
        end
        bus_s.in_valid = 1'b0;
        prev     = dato_sal_s;
        cnt_exp  = 0;
        last_exp = '0;
        for (int k = 1; k <= EJEC_S + 3; k++) begin
            v = (k % 2 == 1) ? AW'(2) : AW'(1);
            dato_sal_s = v;
            @(negedge clk);
            if (k <= EJEC_S && v != prev) begin
                cnt_exp  = (cnt_exp < 255) ? cnt_exp + 1 : 255;
                last_exp = v;
            end
            prev = v;
            if (k == 254 || k == 255 || k == 256 || k == EJEC_S + 3) begin
                n_tests++;
                if (cambios_s !== 8'(cnt_exp) || acum_s !== last_exp) begin
                    n_fail++;
                    $display("FAIL sat_count k=%0d: got cambios=%0d acum=%h want %0d/%h",
                             k, cambios_s, acum_s, cnt_exp, last_exp);
                end
            end
        end
        n_tests++;
        if ({wr_s, ejecutando_s, hecho_s} !== 3'b001) begin
            n_fail++;
            $display("FAIL sat_done: got {wr,ejec,hecho}=%b want 001", {wr_s, ejecutando_s, hecho_s});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.in_valid   = 1'b0;
        bus.in_dir     = '0;
        bus.in_dato    = '0;
        bus.in_fin     = 1'b0;
        bus_s.in_valid = 1'b0;
        bus_s.in_dir   = '0;
        bus_s.in_dato  = '0;
        bus_s.in_fin   = 1'b0;
        dato_sal       = '0;
        dato_sal_s     = '0;
        @(negedge clk);
        test_reset();
        test_load_fixed();
        test_run_tracking();
        test_reset_mid_write();
        test_reset_mid_run();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: time limit reached before the sequence ended");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
